rf_dump: RTL and testbench

RF_DUMP -- requirements
Module: rf_dump

---
 rtl/rf_dump_pkg.sv | 15 +
 rtl/rf_dump_ser.sv | 33 +++
 rtl/rf_dump.sv | 114 +++++++++++
 tb/tb_rf_dump.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rf_dump_pkg.sv
// Shared types and constants for the register-file dump streamer.
package rf_dump_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StIdx,
    StData,
    StFin
  } state_e;

  localparam int unsigned BYTES_PER_REG = 4;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/rf_dump_ser.sv
// 32-bit to 4-byte little-endian serializer: load captures a word, advance shifts out one byte.
module rf_dump_ser
  import rf_dump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        advance,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0] sr_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= load_data;
      cnt_q <= '0;
    end else if (advance) begin
      sr_q  <= {8'h00, sr_q[31:8]};
      cnt_q <= cnt_q + 2'd1;
    end
  end

  assign byte_out = sr_q[7:0];
  assign last     = (cnt_q == 2'(BYTES_PER_REG - 1));

endmodule

// File: rtl/rf_dump.sv
// Streams a sync byte then {index, 4 LE data bytes} for each register in [first_reg, last_reg].
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  state_e     state_q, state_d;
  logic [4:0] cur_q, cur_d;
  logic [4:0] last_q, last_d;
  logic       xfer;
  logic       ser_load, ser_adv, ser_last;
  logic [7:0] ser_byte;

  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_d   = first_reg;
          last_d  = last_reg;
          state_d = (first_reg <= last_reg) ? StHdr : StFin;
        end
      end
      StHdr:  if (xfer) state_d = StIdx;
      StIdx:  if (xfer) state_d = StData;
      StData: begin
        if (xfer && ser_last) begin
          // Equality test so last_reg == 31 ends the dump instead of wrapping cur to 0.
          if (cur_q == last_q) begin
            state_d = StFin;
          end else begin
            cur_d   = cur_q + 5'd1;
            state_d = StIdx;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    ra        = cur_q;
    busy      = 1'b1;
    done      = 1'b0;
    ser_load  = 1'b0;
    ser_adv   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ra   = 5'd0;
        busy = 1'b0;
      end
      StHdr: begin
        out_valid = 1'b1;
        out_data  = SYNC_BYTE;
      end
      StIdx: begin
        out_valid = 1'b1;
        out_data  = {3'b000, cur_q};
        ser_load  = xfer;
      end
      StData: begin
        out_valid = 1'b1;
        out_data  = ser_byte;
        ser_adv   = xfer;
      end
      StFin:   done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  rf_dump_ser u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (rd),
    .advance   (ser_adv),
    .byte_out  (ser_byte),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_rf_dump.sv
// Randomized bench for rf_dump: a byte-queue reference model built from the frame format.
module tb_rf_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_reg, last_reg;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, busy, done;

  logic [31:0] rf [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Register file model: combinational read, write lands at the rising edge.
  assign rd = rf[ra];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  rf_dump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .ra        (ra),
    .rd        (rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_busy"},  32'(busy),      32'd0);
    check_eq({tag, "_done"},  32'(done),      32'd0);
    check_eq({tag, "_data"},  32'(out_data),  32'h00);
    check_eq({tag, "_ra"},    32'(ra),        32'd0);
  endtask

  // One full dump; wr_idx >= 0 overwrites that register on its index-byte transfer edge.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int ready_pct,
                          input int wr_idx, input logic [31:0] wr_val, input bit junk);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] data_prev;
    int   done_cnt, busy_cnt, stall_cnt, last_xfer_cyc, done_cyc, cyc;
    bit   stall_prev, finished;
    if (f <= l) begin
      exp_q.push_back(8'hA5);
      for (int i = int'(f); i <= int'(l); i++) begin
        exp_q.push_back(8'(i));
        for (int b = 0; b < 4; b++) exp_q.push_back(rf[i][8*b +: 8]);
      end
    end
    @(negedge clk);
    start = 1'b1; first_reg = f; last_reg = l;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; done_cnt = 0; busy_cnt = 0; stall_cnt = 0;
    last_xfer_cyc = -1; done_cyc = -1; stall_prev = 1'b0; finished = 1'b0; data_prev = 8'h00;
    while (!finished && cyc < 4000) begin
      wr_en = 1'b0;
      if (stall_prev) begin
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_data", 32'(out_data), 32'(data_prev));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("fin_valid", 32'(out_valid), 32'd0);
      end
      if (busy) busy_cnt++;
      else finished = 1'b1;
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        if (wr_idx >= 0 && got_q.size() == 1 + 5 * (wr_idx - int'(f))) begin
          wr_en = 1'b1; wr_addr = 5'(wr_idx); wr_data = wr_val;
        end
        if (got_q.size() % 5 == 1)
          check_eq("ra_idx", 32'(ra), 32'(int'(f) + (got_q.size() - 1) / 5));
        got_q.push_back(out_data);
        last_xfer_cyc = cyc;
      end
      if (out_valid && !out_ready) stall_cnt++;
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      // Spurious starts while busy (including the FIN cycle) must be ignored.
      start = junk && busy && ($urandom_range(3) == 0);
      if (start) begin
        first_reg = 5'($urandom_range(31));
        last_reg  = 5'($urandom_range(31));
      end
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0;
    start = 1'b0;
    check_eq("finished", 32'(finished), 32'd1);
    check_eq("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("done_cycle", 32'(done_cyc),
             (exp_q.size() == 0) ? 32'd0 : 32'(last_xfer_cyc + 1));
    check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_q.size() + stall_cnt + 1));
    check_idle("post");
  endtask

  task automatic reset_abort();
    int n, guard;
    n = 0; guard = 0;
    @(negedge clk);
    start = 1'b1; first_reg = 5'd3; last_reg = 5'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 3 && guard < 20) begin
      if (out_valid) n++;
      guard++;
      @(negedge clk);
    end
    check_eq("abort_reach", 32'(n), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("abort_nodone", 32'(done), 32'd0);
      check_eq("abort_novalid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) rf_write(5'(i), $urandom);
    rf_write(5'd3, 32'h11223344);
    rf_write(5'd4, 32'hDEADBEEF);
    rf_write(5'd31, 32'h80000001);
    rf_write(5'd0, 32'hCAFEF00D);

    run_dump(5'd3, 5'd4, 100, -1, 32'h0, 1'b0);
    run_dump(5'd31, 5'd31, 100, -1, 32'h0, 1'b0);
    run_dump(5'd5, 5'd2, 100, -1, 32'h0, 1'b0);
    run_dump(5'd3, 5'd4, 40, -1, 32'h0, 1'b0);
    run_dump(5'd0, 5'd1, 70, -1, 32'h0, 1'b1);
    run_dump(5'd3, 5'd4, 100, 4, 32'h0, 1'b0);
    check_eq("rf4_written", rf[4], 32'h0);
    rf_write(5'd4, 32'hDEADBEEF);

    reset_abort();
    run_dump(5'd3, 5'd4, 100, -1, 32'h0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 4; k++) rf_write(5'($urandom_range(31)), $urandom);
      run_dump(5'($urandom_range(31)), 5'($urandom_range(31)), 30 + $urandom_range(70), -1,
               32'h0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
